// File: rtl/control_decode_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : control_decode_pipe_if
// Purpose  : Bundles the fetch-side inputs and the registered ID-stage control
//            outputs of control_decode_pipe.
// Ports    : master modport = fetch/pipeline control side (drives if_valid,
//            if_instr, stall, flush; observes ID outputs).
//            slave modport  = decode stage (the reverse).
// Revision : 1.0 - initial release
// ============================================================================
interface control_decode_pipe_if #(
    parameter int ILL_CNT_W = 8
);
    logic                 if_valid;
    logic [31:0]          if_instr;
    logic                 stall;
    logic                 flush;

    logic                 id_valid;
    logic [2:0]           ImmSel;
    logic [3:0]           ALUSel;
    logic                 ASel;
    logic                 BSel;
    logic                 RegWEn;
    logic                 MemRW;
    logic [1:0]           WBSel;
    logic                 BrUn;
    logic                 is_branch;
    logic                 is_jump;
    logic [2:0]           MemFunct;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] ill_count;

    modport master (
        output if_valid, if_instr, stall, flush,
        input  id_valid, ImmSel, ALUSel, ASel, BSel, RegWEn, MemRW, WBSel,
               BrUn, is_branch, is_jump, MemFunct, illegal, ill_count
    );

    modport slave (
        input  if_valid, if_instr, stall, flush,
        output id_valid, ImmSel, ALUSel, ASel, BSel, RegWEn, MemRW, WBSel,
               BrUn, is_branch, is_jump, MemFunct, illegal, ill_count
    );
endinterface
`default_nettype wire

// File: rtl/control_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : control_decode_pipe
// Purpose  : RV32I control decoder with a single ID pipeline register stage.
//            Decodes the fetched instruction into datapath control signals,
//            registers them (stall holds, flush inserts a bubble) and keeps a
//            saturating count of captured illegal instructions.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - control_decode_pipe_if.slave (fetch inputs, ID outputs)
// Revision : 1.0 - initial release
// ============================================================================
module control_decode_pipe #(
    parameter int ENABLE_SHIFTS  = 1,
    parameter int ENABLE_SUBWORD = 1,
    parameter int ILL_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_decode_pipe_if.slave bus
);

    // instr[6:2] opcode groups
    localparam logic [4:0] c_OP_LOAD   = 5'b00000;
    localparam logic [4:0] c_OP_IMM    = 5'b00100;
    localparam logic [4:0] c_OP_AUIPC  = 5'b00101;
    localparam logic [4:0] c_OP_STORE  = 5'b01000;
    localparam logic [4:0] c_OP_REG    = 5'b01100;
    localparam logic [4:0] c_OP_LUI    = 5'b01101;
    localparam logic [4:0] c_OP_BRANCH = 5'b11000;
    localparam logic [4:0] c_OP_JALR   = 5'b11001;
    localparam logic [4:0] c_OP_JAL    = 5'b11011;

    localparam logic [2:0] c_IMM_I = 3'b001;
    localparam logic [2:0] c_IMM_S = 3'b010;
    localparam logic [2:0] c_IMM_B = 3'b011;
    localparam logic [2:0] c_IMM_J = 3'b100;
    localparam logic [2:0] c_IMM_U = 3'b101;

    localparam logic [1:0] c_WB_MEM = 2'b00;
    localparam logic [1:0] c_WB_ALU = 2'b01;
    localparam logic [1:0] c_WB_PC4 = 2'b10;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SRA  = 4'b1101;
    localparam logic [3:0] c_ALU_PASS = 4'b1111;

    localparam logic c_SHIFTS_ON  = (ENABLE_SHIFTS != 0);
    localparam logic c_SUBWORD_ON = (ENABLE_SUBWORD != 0);

    // Legal-funct3 masks: bit i set means funct3 == i is a legal access.
    // Without sub-word support only the word forms (funct3 010) remain.
    localparam logic [7:0] c_LD_OK = c_SUBWORD_ON ? 8'b0011_0111 : 8'b0000_0100;
    localparam logic [7:0] c_ST_OK = c_SUBWORD_ON ? 8'b0000_0111 : 8'b0000_0100;

    localparam logic [ILL_CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [ILL_CNT_W-1:0] c_CNT_ONE = ILL_CNT_W'(1);

    typedef struct packed {
        logic       illegal;
        logic [2:0] imm_sel;
        logic [3:0] alu_sel;
        logic       a_sel;
        logic       b_sel;
        logic       reg_wen;
        logic       mem_rw;
        logic [1:0] wb_sel;
        logic       br_un;
        logic       is_branch;
        logic       is_jump;
        logic [2:0] mem_funct;
    } ctrl_t;

    logic [6:0] w_f7;
    logic       w_b30;
    logic [2:0] w_f3;
    logic [4:0] w_op;
    logic [1:0] w_len;
    logic       w_unused;
    logic       w_bad;
    ctrl_t      w_dec;

    logic       r_id_valid;
    ctrl_t      r_ctrl;
    logic [ILL_CNT_W-1:0] r_ill_count;

    assign w_f7  = bus.if_instr[31:25];
    assign w_b30 = bus.if_instr[30];
    assign w_f3  = bus.if_instr[14:12];
    assign w_op  = bus.if_instr[6:2];
    assign w_len = bus.if_instr[1:0];
    // Register specifiers and immediate bits play no part in control decode.
    assign w_unused = ^{bus.if_instr[24:15], bus.if_instr[11:7]};

    always_comb begin
        w_dec = '0;
        w_bad = 1'b0;
        case (w_op)
            c_OP_REG: begin
                w_dec.alu_sel = {w_b30, w_f3};
                w_dec.reg_wen = 1'b1;
                w_dec.wb_sel  = c_WB_ALU;
                // Only sub and sra carry instr[30]=1
                if (w_b30 && (w_f3 != 3'b000) && (w_f3 != 3'b101)) w_bad = 1'b1;
                if (!c_SHIFTS_ON && ((w_f3 == 3'b001) || (w_f3 == 3'b101))) w_bad = 1'b1;
            end
            c_OP_IMM: begin
                w_dec.imm_sel = c_IMM_I;
                w_dec.alu_sel = {1'b0, w_f3};
                w_dec.b_sel   = 1'b1;
                w_dec.reg_wen = 1'b1;
                w_dec.wb_sel  = c_WB_ALU;
                if (w_f3 == 3'b001) begin
                    if (!c_SHIFTS_ON || (w_f7 != 7'b0000000)) w_bad = 1'b1;
                end else if (w_f3 == 3'b101) begin
                    // instr[30] selects srai over srli; the rest of funct7 must be clean
                    if (w_b30) begin
                        w_dec.alu_sel = c_ALU_SRA;
                        if (w_f7 != 7'b0100000) w_bad = 1'b1;
                    end else if (w_f7 != 7'b0000000) begin
                        w_bad = 1'b1;
                    end
                    if (!c_SHIFTS_ON) w_bad = 1'b1;
                end
            end
            c_OP_LOAD: begin
                w_dec.imm_sel   = c_IMM_I;
                w_dec.alu_sel   = c_ALU_ADD;
                w_dec.b_sel     = 1'b1;
                w_dec.reg_wen   = 1'b1;
                w_dec.wb_sel    = c_WB_MEM;
                w_dec.mem_funct = w_f3;
                if (!c_LD_OK[w_f3]) w_bad = 1'b1;
            end
            c_OP_STORE: begin
                w_dec.imm_sel   = c_IMM_S;
                w_dec.alu_sel   = c_ALU_ADD;
                w_dec.b_sel     = 1'b1;
                w_dec.mem_rw    = 1'b1;
                w_dec.mem_funct = w_f3;
                if (!c_ST_OK[w_f3]) w_bad = 1'b1;
            end
            c_OP_BRANCH: begin
                w_dec.imm_sel   = c_IMM_B;
                w_dec.alu_sel   = c_ALU_ADD;
                w_dec.a_sel     = 1'b1;
                w_dec.b_sel     = 1'b1;
                w_dec.is_branch = 1'b1;
                w_dec.br_un     = w_f3[1];
                if ((w_f3 == 3'b010) || (w_f3 == 3'b011)) w_bad = 1'b1;
            end
            c_OP_JAL: begin
                w_dec.imm_sel = c_IMM_J;
                w_dec.alu_sel = c_ALU_ADD;
                w_dec.a_sel   = 1'b1;
                w_dec.b_sel   = 1'b1;
                w_dec.reg_wen = 1'b1;
                w_dec.wb_sel  = c_WB_PC4;
                w_dec.is_jump = 1'b1;
            end
            c_OP_JALR: begin
                w_dec.imm_sel = c_IMM_I;
                w_dec.alu_sel = c_ALU_ADD;
                w_dec.b_sel   = 1'b1;
                w_dec.reg_wen = 1'b1;
                w_dec.wb_sel  = c_WB_PC4;
                w_dec.is_jump = 1'b1;
                if (w_f3 != 3'b000) w_bad = 1'b1;
            end
            c_OP_LUI: begin
                w_dec.imm_sel = c_IMM_U;
                w_dec.alu_sel = c_ALU_PASS;
                w_dec.b_sel   = 1'b1;
                w_dec.reg_wen = 1'b1;
                w_dec.wb_sel  = c_WB_ALU;
            end
            c_OP_AUIPC: begin
                w_dec.imm_sel = c_IMM_U;
                w_dec.alu_sel = c_ALU_ADD;
                w_dec.a_sel   = 1'b1;
                w_dec.b_sel   = 1'b1;
                w_dec.reg_wen = 1'b1;
                w_dec.wb_sel  = c_WB_ALU;
            end
            default: w_bad = 1'b1;
        endcase

        // Compressed/non-32-bit encodings are not supported
        if (w_len != 2'b11) w_bad = 1'b1;

        // An illegal instruction must not cause any side effect downstream
        if (w_bad) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid  <= 1'b0;
            r_ctrl      <= '0;
            r_ill_count <= '0;
        end else if (bus.flush) begin
            r_id_valid <= 1'b0;
            r_ctrl     <= '0;
        end else if (!bus.stall) begin
            r_id_valid <= bus.if_valid;
            r_ctrl     <= w_dec;
            if (bus.if_valid && w_dec.illegal && (r_ill_count != c_CNT_MAX)) begin
                r_ill_count <= r_ill_count + c_CNT_ONE;
            end
        end
    end

    assign bus.id_valid  = r_id_valid;
    assign bus.ImmSel    = r_ctrl.imm_sel;
    assign bus.ALUSel    = r_ctrl.alu_sel;
    assign bus.ASel      = r_ctrl.a_sel;
    assign bus.BSel      = r_ctrl.b_sel;
    assign bus.RegWEn    = r_ctrl.reg_wen;
    assign bus.MemRW     = r_ctrl.mem_rw;
    assign bus.WBSel     = r_ctrl.wb_sel;
    assign bus.BrUn      = r_ctrl.br_un;
    assign bus.is_branch = r_ctrl.is_branch;
    assign bus.is_jump   = r_ctrl.is_jump;
    assign bus.MemFunct  = r_ctrl.mem_funct;
    assign bus.illegal   = r_ctrl.illegal;
    assign bus.ill_count = r_ill_count;

endmodule
`default_nettype wire

// File: tb/tb_control_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_decode_pipe
// Purpose  : Self-checking bench for control_decode_pipe. Three instances
//            (default, shifts+subword disabled, 2-bit illegal counter) share
//            one stimulus stream and are compared against a rule-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_decode_pipe;

    typedef struct packed {
        logic       illegal;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       a;
        logic       b;
        logic       wen;
        logic       mrw;
        logic [1:0] wb;
        logic       brun;
        logic       br;
        logic       jmp;
        logic [2:0] mf;
    } exp_t;

    typedef struct {
        string       nm;
        logic        v;
        logic [31:0] ins;
        logic        ev;
        logic [2:0]  imm;
        logic [3:0]  alu;
        logic        wen;
        logic        mrw;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    control_decode_pipe_if #(.ILL_CNT_W(8)) bus0 ();
    control_decode_pipe_if #(.ILL_CNT_W(8)) bus1 ();
    control_decode_pipe_if #(.ILL_CNT_W(2)) bus2 ();

    assign bus0.if_valid = if_valid;
    assign bus0.if_instr = if_instr;
    assign bus0.stall    = stall;
    assign bus0.flush    = flush;
    assign bus1.if_valid = if_valid;
    assign bus1.if_instr = if_instr;
    assign bus1.stall    = stall;
    assign bus1.flush    = flush;
    assign bus2.if_valid = if_valid;
    assign bus2.if_instr = if_instr;
    assign bus2.stall    = stall;
    assign bus2.flush    = flush;

    control_decode_pipe #(.ENABLE_SHIFTS(1), .ENABLE_SUBWORD(1), .ILL_CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    control_decode_pipe #(.ENABLE_SHIFTS(0), .ENABLE_SUBWORD(0), .ILL_CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    control_decode_pipe #(.ENABLE_SHIFTS(1), .ENABLE_SUBWORD(1), .ILL_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    exp_t        got [3];
    logic        gv  [3];
    logic [31:0] gc  [3];

    assign got[0] = {bus0.illegal, bus0.ImmSel, bus0.ALUSel, bus0.ASel, bus0.BSel, bus0.RegWEn,
                     bus0.MemRW, bus0.WBSel, bus0.BrUn, bus0.is_branch, bus0.is_jump, bus0.MemFunct};
    assign got[1] = {bus1.illegal, bus1.ImmSel, bus1.ALUSel, bus1.ASel, bus1.BSel, bus1.RegWEn,
                     bus1.MemRW, bus1.WBSel, bus1.BrUn, bus1.is_branch, bus1.is_jump, bus1.MemFunct};
    assign got[2] = {bus2.illegal, bus2.ImmSel, bus2.ALUSel, bus2.ASel, bus2.BSel, bus2.RegWEn,
                     bus2.MemRW, bus2.WBSel, bus2.BrUn, bus2.is_branch, bus2.is_jump, bus2.MemFunct};
    assign gv[0] = bus0.id_valid;
    assign gv[1] = bus1.id_valid;
    assign gv[2] = bus2.id_valid;
    assign gc[0] = 32'(bus0.ill_count);
    assign gc[1] = 32'(bus1.ill_count);
    assign gc[2] = 32'(bus2.ill_count);

    // Reference state of each instance
    bit   cfg_sh  [3] = '{1'b1, 1'b0, 1'b1};
    bit   cfg_sub [3] = '{1'b1, 1'b0, 1'b1};
    int   cnt_max [3] = '{255, 255, 3};
    logic ev  [3];
    exp_t ec  [3];
    int   ecnt[3];

    // Instruction meaning from the RV32I rules, per opcode class
    function automatic exp_t model(input logic [31:0] ins, input bit sh, input bit sub);
        exp_t       e;
        bit         bad;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [7:0] ld_ok;
        logic [7:0] st_ok;
        e     = '0;
        bad   = 1'b0;
        f3    = ins[14:12];
        f7    = ins[31:25];
        ld_ok = sub ? 8'b0011_0111 : 8'b0000_0100;
        st_ok = sub ? 8'b0000_0111 : 8'b0000_0100;
        case (ins[6:0])
            7'h33: begin
                e.alu = {ins[30], f3}; e.wen = 1'b1; e.wb = 2'b01;
                if (ins[30] && f3 != 3'd0 && f3 != 3'd5) bad = 1'b1;
                if (!sh && (f3 == 3'd1 || f3 == 3'd5)) bad = 1'b1;
            end
            7'h13: begin
                e.imm = 3'd1; e.b = 1'b1; e.wen = 1'b1; e.wb = 2'b01; e.alu = {1'b0, f3};
                if (f3 == 3'd1) bad = !sh || (f7 != 7'h00);
                else if (f3 == 3'd5) begin
                    bad = !sh || (f7 != 7'h00 && f7 != 7'h20);
                    if (f7 == 7'h20) e.alu = 4'hD;
                end
            end
            7'h03: begin
                e.imm = 3'd1; e.b = 1'b1; e.wen = 1'b1; e.mf = f3; bad = !ld_ok[f3];
            end
            7'h23: begin
                e.imm = 3'd2; e.b = 1'b1; e.mrw = 1'b1; e.mf = f3; bad = !st_ok[f3];
            end
            7'h63: begin
                e.imm = 3'd3; e.a = 1'b1; e.b = 1'b1; e.br = 1'b1; e.brun = f3[1];
                bad = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h6F: begin
                e.imm = 3'd4; e.a = 1'b1; e.b = 1'b1; e.wen = 1'b1; e.wb = 2'b10; e.jmp = 1'b1;
            end
            7'h67: begin
                e.imm = 3'd1; e.b = 1'b1; e.wen = 1'b1; e.wb = 2'b10; e.jmp = 1'b1;
                bad = (f3 != 3'd0);
            end
            7'h37: begin
                e.imm = 3'd5; e.b = 1'b1; e.alu = 4'hF; e.wen = 1'b1; e.wb = 2'b01;
            end
            7'h17: begin
                e.imm = 3'd5; e.a = 1'b1; e.b = 1'b1; e.wen = 1'b1; e.wb = 2'b01;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            e = '0;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            ev[d]   = 1'b0;
            ec[d]   = '0;
            ecnt[d] = 0;
        end
    endtask

    task automatic check_model(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s dut%0d id_valid", tag, d), 32'(gv[d]), 32'(ev[d]));
            chk($sformatf("%s dut%0d ctrl", tag, d), 32'(got[d]), 32'(ec[d]));
            chk($sformatf("%s dut%0d ill_count", tag, d), gc[d], 32'(ecnt[d]));
        end
    endtask

    // One clock: drive at negedge, capture at posedge, compare 1 time unit later
    task automatic cyc(input logic v, input logic [31:0] ins, input logic s, input logic f,
                       input string tag);
        @(negedge clk);
        if_valid = v;
        if_instr = ins;
        stall    = s;
        flush    = f;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (f) begin
                ev[d] = 1'b0;
                ec[d] = '0;
            end else if (!s) begin
                ev[d] = v;
                ec[d] = model(ins, cfg_sh[d], cfg_sub[d]);
                if (v && ec[d].illegal && ecnt[d] < cnt_max[d]) ecnt[d]++;
            end
        end
        #1;
        check_model(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0:  w[6:0] = 7'h03;
            1:  w[6:0] = 7'h13;
            2:  w[6:0] = 7'h17;
            3:  w[6:0] = 7'h23;
            4:  begin w[6:0] = 7'h33; w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            5:  w[6:0] = 7'h37;
            6:  w[6:0] = 7'h63;
            7:  begin w[6:0] = 7'h67; if ($urandom_range(0, 1) == 1) w[14:12] = 3'd0; end
            8:  w[6:0] = 7'h6F;
            9:  begin w[6:0] = 7'h13; w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            10: w = 32'hFFFF_FFFF;
            default: ;
        endcase
        return w;
    endfunction

    vec_t tbl [14];
    int   sat_exp [5];

    initial begin
        tbl[0]  = '{"sub",      1'b1, 32'h40B50533, 1'b1, 3'd0, 4'h8, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{"add",      1'b1, 32'h00B50533, 1'b1, 3'd0, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{"addi",     1'b1, 32'h00150513, 1'b1, 3'd1, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{"srai",     1'b1, 32'h40155513, 1'b1, 3'd1, 4'hD, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{"lw",       1'b1, 32'h00052503, 1'b1, 3'd1, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{"sw",       1'b1, 32'h00C5A023, 1'b1, 3'd2, 4'h0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{"beq",      1'b1, 32'h00000063, 1'b1, 3'd3, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{"jal",      1'b1, 32'h0000006F, 1'b1, 3'd4, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{"lui",      1'b1, 32'h000012B7, 1'b1, 3'd5, 4'hF, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{"auipc",    1'b1, 32'h00000297, 1'b1, 3'd5, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{"all_ones", 1'b1, 32'hFFFFFFFF, 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{"r_bad30",  1'b1, 32'h40B51533, 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{"compress", 1'b1, 32'h00000001, 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{"invalid",  1'b0, 32'h00150513, 1'b0, 3'd1, 4'h0, 1'b1, 1'b0, 1'b0};
        sat_exp = '{1, 2, 3, 3, 3};

        model_clear();

        // Reset state
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // sll on the instance without shift support
        cyc(1'b1, 32'h00B51533, 1'b0, 1'b0, "sll");
        chk("sll noshift illegal/wen", 32'({got[1].illegal, got[1].wen}), 32'h2);
        chk("sll noshift count", gc[1], 32'd1);
        chk("sll default alu", 32'({got[0].illegal, got[0].alu}), 32'h01);

        // Table of single-cycle decodes on the default instance
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].v, tbl[i].ins, 1'b0, 1'b0, tbl[i].nm);
            chk({"tbl ", tbl[i].nm},
                32'({gv[0], got[0].imm, got[0].alu, got[0].wen, got[0].mrw, got[0].illegal}),
                32'({tbl[i].ev, tbl[i].imm, tbl[i].alu, tbl[i].wen, tbl[i].mrw, tbl[i].ill}));
        end

        // Store held through a 3-cycle stall while fetch keeps changing
        cyc(1'b1, 32'h00C5A023, 1'b0, 1'b0, "sw_load");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, rand_instr(), 1'b1, 1'b0, "sw_stall");
            chk($sformatf("stall hold %0d", i),
                32'({got[0].imm, got[0].mrw, got[0].mf}), 32'({3'd2, 1'b1, 3'd2}));
        end

        // Flush wins over stall
        cyc(1'b1, 32'h00000063, 1'b1, 1'b1, "flush");
        chk("flush bubble", 32'({gv[0], got[0].br}), 32'h0);

        // Asynchronous reset with jal registered
        cyc(1'b1, 32'h0000006F, 1'b0, 1'b0, "jal_pre_rst");
        chk("jal registered", 32'({got[0].imm, got[0].jmp}), 32'({3'd4, 1'b1}));
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_model("async_rst");
        @(posedge clk);
        #1;
        check_model("rst_held");
        @(negedge clk);
        rst_n = 1'b1;

        // 2-bit counter saturation
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, "sat");
            chk($sformatf("sat count %0d", i), gc[2], 32'(sat_exp[i]));
        end

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 9) < 8), rand_instr(),
                ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
